// File: rtl/blakeminer_pkg.sv
// Shared definitions for the golden-nonce result path: nonce width and the
// output-pacing FSM encoding.
package blakeminer_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } gn_state_e;

endpackage

// File: rtl/nonce_fifo.sv
// Small synchronous nonce queue with flush; storage is not reset, only the
// pointers and occupancy are.
module nonce_fifo
  import blakeminer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               hash_clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [NONCE_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [NONCE_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Push is accepted only while !full_o and pop only while !empty_o; both may
  // happen in one cycle. A pop when full frees its slot from the next cycle.
  logic [NONCE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge hash_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge hash_clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/golden_nonce_arbiter.sv
// Collects golden nonces from several hash cores, arbitrates them round-robin
// into a queue and emits them as strobes spaced at least MIN_GAP cycles apart.
module golden_nonce_arbiter
  import blakeminer_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 8
) (
  input  logic                         hash_clk,
  input  logic                         rst,
  input  logic [NUM_CORES-1:0]         gn_match_i,
  input  logic [NUM_CORES*NONCE_W-1:0] golden_nonce_i,
  input  logic                         new_work,
  output logic                         is_golden_ticket,
  output logic [NONCE_W-1:0]           golden_nonce,
  output logic [7:0]                   drop_count,
  output gn_state_e                    dbg_state_o,
  output logic [1:0]                   dbg_rr_ptr_o
);

  localparam int RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] pend_q, pend_d, grant_oh;
  logic [NONCE_W-1:0]   pend_nonce_q [NUM_CORES];
  logic [NONCE_W-1:0]   pend_nonce_d [NUM_CORES];
  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d, grant_idx;
  logic                 grant_vld, drop_any;
  logic [7:0]           drop_count_q, drop_count_d;
  gn_state_e            state_q, state_d;
  logic [7:0]           gap_q, gap_d;
  logic                 ticket_q, ticket_d;
  logic [NONCE_W-1:0]   nonce_out_q, nonce_out_d;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [NONCE_W-1:0]   fifo_head;

  // Round-robin search starting at rr_ptr; new_work suppresses the grant since
  // the queue is being flushed in the same cycle.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!fifo_full && !new_work) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (!grant_vld && pend_q[(int'(rr_ptr_q) + k) % NUM_CORES]) begin
          grant_vld = 1'b1;
          grant_idx = RR_W'((int'(rr_ptr_q) + k) % NUM_CORES);
        end
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      grant_oh[i] = grant_vld && (int'(grant_idx) == i);
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // A granted core may reload in the cycle its old nonce leaves for the queue.
  always_comb begin
    pend_d       = pend_q;
    pend_nonce_d = pend_nonce_q;
    drop_any     = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (new_work) begin
        pend_d[i] = 1'b0;
      end else if (gn_match_i[i] && (!pend_q[i] || grant_oh[i])) begin
        pend_d[i]       = 1'b1;
        pend_nonce_d[i] = golden_nonce_i[i*NONCE_W +: NONCE_W];
      end else begin
        if (gn_match_i[i]) drop_any = 1'b1;
        if (grant_oh[i])   pend_d[i] = 1'b0;
      end
    end
    drop_count_d = drop_count_q;
    if (drop_any && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  // Output pacing: strobe on pop, then hold off for MIN_GAP cycles in total.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    ticket_d    = 1'b0;
    nonce_out_d = nonce_out_q;
    fifo_pop    = 1'b0;
    if (new_work) begin
      state_d = ST_IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            nonce_out_d = fifo_head;
            ticket_d    = 1'b1;
            gap_d       = 8'(MIN_GAP - 1);
            state_d     = ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q <= 8'd1) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge hash_clk or posedge rst) begin
    if (rst) begin
      pend_q       <= '0;
      rr_ptr_q     <= '0;
      drop_count_q <= '0;
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      ticket_q     <= 1'b0;
      nonce_out_q  <= '0;
    end else begin
      pend_q       <= pend_d;
      rr_ptr_q     <= rr_ptr_d;
      drop_count_q <= drop_count_d;
      state_q      <= state_d;
      gap_q        <= gap_d;
      ticket_q     <= ticket_d;
      nonce_out_q  <= nonce_out_d;
    end
  end

  always_ff @(posedge hash_clk) begin
    pend_nonce_q <= pend_nonce_d;
  end

  nonce_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .hash_clk    (hash_clk),
    .rst         (rst),
    .flush_i     (new_work),
    .push_i      (grant_vld),
    .push_data_i (pend_nonce_q[grant_idx]),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign is_golden_ticket = ticket_q;
  assign golden_nonce     = nonce_out_q;
  assign drop_count       = drop_count_q;
  assign dbg_state_o      = state_q;
  assign dbg_rr_ptr_o     = 2'(rr_ptr_q);

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Self-checking bench for golden_nonce_arbiter: vector table plus directed
// sequences for queue overflow, flush and mid-gap reset.
module tb_golden_nonce_arbiter;
  import blakeminer_pkg::*;

  localparam int NC = 2;

  logic                hash_clk = 1'b0;
  logic                rst = 1'b1;
  logic [NC-1:0]       gn_match_i = '0;
  logic [NC*32-1:0]    golden_nonce_i = '0;
  logic                new_work = 1'b0;
  logic                is_golden_ticket;
  logic [31:0]         golden_nonce;
  logic [7:0]          drop_count;
  gn_state_e           dbg_state_o;
  logic [1:0]          dbg_rr_ptr_o;

  golden_nonce_arbiter #(.NUM_CORES(NC), .FIFO_DEPTH(4), .MIN_GAP(8)) dut (
    .hash_clk         (hash_clk),
    .rst              (rst),
    .gn_match_i       (gn_match_i),
    .golden_nonce_i   (golden_nonce_i),
    .new_work         (new_work),
    .is_golden_ticket (is_golden_ticket),
    .golden_nonce     (golden_nonce),
    .drop_count       (drop_count),
    .dbg_state_o      (dbg_state_o),
    .dbg_rr_ptr_o     (dbg_rr_ptr_o)
  );

  // clock / reset
  always #5 hash_clk = ~hash_clk;
  int cyc = 0;
  always @(posedge hash_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int last_strobe_cyc = -1;
  int prev_strobe_cyc = -1;
  int last_drv_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  always @(posedge hash_clk) begin
    #1;
    if (!rst && is_golden_ticket) begin
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got nonce 0x%08h, expected no strobe", golden_nonce);
      end else begin
        check("strobe_nonce", golden_nonce, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge hash_clk);
  endtask

  task automatic pulse(input logic [NC-1:0] m, input logic [31:0] n0, input logic [31:0] n1,
                       input logic nw);
    @(negedge hash_clk);
    gn_match_i     = m;
    golden_nonce_i = {n1, n0};
    new_work       = nw;
    last_drv_cyc   = cyc;
    @(negedge hash_clk);
    gn_match_i = '0;
    new_work   = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge hash_clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d strobes outstanding after %0d cycles, expected 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_reset;
    @(negedge hash_clk);
    rst = 1'b1;
    gn_match_i = '0;
    new_work = 1'b0;
    idle(3);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] n0;
    logic [31:0] n1;
    int          n_exp;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  rr;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{2'b01, 32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF, 32'h0,        2'd1, 32'hDEADBEEF};
    vecs[1] = '{2'b11, 32'h11111111, 32'h22222222, 2, 32'h22222222, 32'h11111111, 2'd1, 32'h11111111};
    vecs[2] = '{2'b10, 32'h0,        32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'h0,        2'd0, 32'hFFFFFFFF};
    vecs[3] = '{2'b11, 32'h00000000, 32'h80000001, 2, 32'h00000000, 32'h80000001, 2'd0, 32'h80000001};
    vecs[4] = '{2'b00, 32'h0,        32'h0,        0, 32'h0,        32'h0,        2'd0, 32'h80000001};

    // reset state
    idle(3);
    check("rst_ticket", 32'(is_golden_ticket), 32'd0);
    check("rst_nonce", golden_nonce, 32'h0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    rst = 1'b0;
    idle(2);
    check("post_rst_ticket", 32'(is_golden_ticket), 32'd0);

    // single match latency
    exp_q.push_back(32'h12345678);
    pulse(2'b01, 32'h12345678, 32'h0, 1'b0);
    drain("single_drain", 20);
    check("single_latency", 32'(last_strobe_cyc - last_drv_cyc), 32'd3);
    check("single_nonce", golden_nonce, 32'h12345678);
    check("single_drop", 32'(drop_count), 32'd0);
    idle(12);

    // simultaneous matches from a fresh round-robin pointer
    do_reset();
    idle(2);
    exp_q.push_back(32'h0000000A);
    exp_q.push_back(32'h0000000B);
    pulse(2'b11, 32'h0000000A, 32'h0000000B, 1'b0);
    drain("pair_drain", 40);
    check("pair_spacing", 32'(last_strobe_cyc - prev_strobe_cyc), 32'd8);
    idle(12);
    check("pair_rr", 32'(dbg_rr_ptr_o), 32'd0);

    // vector table
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].n_exp > 0) exp_q.push_back(vecs[v].e0);
      if (vecs[v].n_exp > 1) exp_q.push_back(vecs[v].e1);
      pulse(vecs[v].mask, vecs[v].n0, vecs[v].n1, 1'b0);
      drain($sformatf("vec%0d_drain", v), 40);
      idle(12);
      check($sformatf("vec%0d_rr", v), 32'(dbg_rr_ptr_o), 32'(vecs[v].rr));
      check($sformatf("vec%0d_hold", v), golden_nonce, vecs[v].last);
      check($sformatf("vec%0d_drop", v), 32'(drop_count), 32'd0);
    end

    // core1 matching every cycle overruns the queue
    for (int v = 1; v <= 6; v++) exp_q.push_back(32'(v));
    exp_q.push_back(32'd12);
    for (int v = 1; v <= 12; v++) begin
      @(negedge hash_clk);
      gn_match_i     = 2'b10;
      golden_nonce_i = {32'(v), 32'h0};
    end
    @(negedge hash_clk);
    gn_match_i = '0;
    drain("stream_drain", 120);
    check("stream_drop", 32'(drop_count), 32'd5);
    idle(12);
    check("stream_rr", 32'(dbg_rr_ptr_o), 32'd0);

    // new_work during gap flushes the second result; its own match is ignored
    exp_q.push_back(32'h000000A1);
    pulse(2'b11, 32'h000000A1, 32'h000000B2, 1'b0);
    drain("flush_drain", 20);
    idle(1);
    pulse(2'b01, 32'h000000C3, 32'h0, 1'b1);
    idle(30);
    check("flush_hold", golden_nonce, 32'h000000A1);
    check("flush_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check("flush_drop", 32'(drop_count), 32'd5);

    // reset mid-gap with three entries queued
    exp_q.push_back(32'h000000D1);
    pulse(2'b01, 32'h000000D1, 32'h0, 1'b0);
    drain("rstgap_drain", 20);
    pulse(2'b01, 32'h000000D2, 32'h0, 1'b0);
    pulse(2'b01, 32'h000000D3, 32'h0, 1'b0);
    pulse(2'b01, 32'h000000D4, 32'h0, 1'b0);
    @(negedge hash_clk);
    #2 rst = 1'b1;
    #1;
    check("rstgap_ticket", 32'(is_golden_ticket), 32'd0);
    check("rstgap_nonce", golden_nonce, 32'h0);
    check("rstgap_drop", 32'(drop_count), 32'd0);
    check("rstgap_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check("rstgap_rr", 32'(dbg_rr_ptr_o), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(30);
    check("rstgap_quiet", golden_nonce, 32'h0);
    exp_q.push_back(32'h5A5A5A5A);
    pulse(2'b01, 32'h5A5A5A5A, 32'h0, 1'b0);
    drain("rstgap_new_drain", 20);
    check("rstgap_new_latency", 32'(last_strobe_cyc - last_drv_cyc), 32'd3);
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
